// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART transmit-side framer.
// Contents: FSM state enum, default header bytes, byte/length/checksum
// widths and a buffer index width helper.
// Optional feature macro: FRAME_CKSUM_EN (adds the S_CKS state).
package uart_frame_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned CKS_W  = 8;

    localparam logic [BYTE_W-1:0] HDR0_DEFAULT = 8'h55;
    localparam logic [BYTE_W-1:0] HDR1_DEFAULT = 8'hAA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_LEN,
        S_PAY
`ifdef FRAME_CKSUM_EN
        ,
        S_CKS
`endif
    } state_e;

    // Address width of a buffer holding 'depth' entries (at least one bit).
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_pack_if.sv
// Payload-in / transmitter-out signal bundle of the UART framer.
// slave : framer side (consumes payload, drives the transmitter).
// master: environment side (produces payload, models the transmitter).
// Signals: pl_data_i/pl_valid_i/pl_last_i/pl_ready_o payload handshake,
// tx_data_o/tx_en_o/tx_done_i transmitter pacing, busy_o, frame_done_o.
interface uart_frame_pack_if;
    import uart_frame_pkg::*;

    logic [BYTE_W-1:0] pl_data_i;
    logic              pl_valid_i;
    logic              pl_last_i;
    logic              pl_ready_o;
    logic [BYTE_W-1:0] tx_data_o;
    logic              tx_en_o;
    logic              tx_done_i;
    logic              busy_o;
    logic              frame_done_o;

    modport slave (
        input  pl_data_i, pl_valid_i, pl_last_i, tx_done_i,
        output pl_ready_o, tx_data_o, tx_en_o, busy_o, frame_done_o
    );

    modport master (
        output pl_data_i, pl_valid_i, pl_last_i, tx_done_i,
        input  pl_ready_o, tx_data_o, tx_en_o, busy_o, frame_done_o
    );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer for the UART framer: DEPTH x 8 register file with one
// synchronous write port and one combinational read port.
// Ports: clk_i; we/wr_idx/wr_data write port; rd_idx -> rd_data read port.
// Contents are data only and need no reset: a frame is always written
// before it is read.
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clk_i,
    input  logic              we,
    input  logic [AW-1:0]     wr_idx,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_idx,
    output logic [BYTE_W-1:0] rd_data
);

    logic [BYTE_W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read port; the framer only presents indices below the frame length.
    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/uart_frame_pack.sv
// UART transmit-side framer: collects up to DEPTH payload bytes, then sends
// HDR0, HDR1, LEN, payload[0..LEN-1] and (optionally) a checksum byte, one
// byte per tx_en_o pulse, pacing on tx_done_i.
// Ports: clk_i, rst_i (async, active-high); bus (uart_frame_pack_if.slave)
// carrying the payload handshake, transmitter pacing, busy_o, frame_done_o.
// Optional feature macro: FRAME_CKSUM_EN appends sum(LEN, payload) mod 256.
module uart_frame_pack
    import uart_frame_pkg::*;
#(
    parameter int unsigned       DEPTH = 16,
    parameter logic [BYTE_W-1:0] HDR0  = HDR0_DEFAULT,
    parameter logic [BYTE_W-1:0] HDR1  = HDR1_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    uart_frame_pack_if.slave  bus
);

    localparam int unsigned AW = idx_width(DEPTH);

    state_e            state_q, state_n;
    logic [LEN_W-1:0]  cnt_q, cnt_n;
    logic [AW-1:0]     idx_q, idx_n;
    logic              pl_ready_q, pl_ready_n;
    logic              busy_q, busy_n;
    logic              frame_done_q, frame_done_n;
    logic              tx_en_q, tx_en_n;
    logic [BYTE_W-1:0] tx_data_q, tx_data_n;
`ifdef FRAME_CKSUM_EN
    logic [CKS_W-1:0]  cks_q, cks_n;
`endif

    logic              accept_c;
    logic              close_c;
    logic              done_c;
    logic              last_pay_c;
    logic [AW-1:0]     rd_idx_c;
    logic [BYTE_W-1:0] rd_data_c;

    // Handshake qualifiers.
    assign accept_c   = bus.pl_valid_i & pl_ready_q & (state_q == S_IDLE);
    assign close_c    = accept_c & (bus.pl_last_i | (cnt_q == LEN_W'(DEPTH - 1)));
    // A done pulse that coincides with the issue cycle belongs to no byte.
    assign done_c     = bus.tx_done_i & ~tx_en_q & (state_q != S_IDLE);
    assign last_pay_c = (LEN_W'(idx_q) == (cnt_q - LEN_W'(1)));

    // Read address is the byte issued next: payload[0] from S_LEN, else idx+1.
    assign rd_idx_c = (state_q == S_PAY && !last_pay_c) ? (idx_q + AW'(1)) : '0;

    uart_frame_buf #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk_i   (clk_i),
        .we      (accept_c),
        .wr_idx  (AW'(cnt_q)),
        .wr_data (bus.pl_data_i),
        .rd_idx  (rd_idx_c),
        .rd_data (rd_data_c)
    );

    // Next-state and next-output logic; entering a send state issues its byte.
    always_comb begin
        state_n      = state_q;
        cnt_n        = cnt_q;
        idx_n        = idx_q;
        pl_ready_n   = pl_ready_q;
        busy_n       = busy_q;
        frame_done_n = 1'b0;
        tx_en_n      = 1'b0;
        tx_data_n    = tx_data_q;
`ifdef FRAME_CKSUM_EN
        cks_n        = cks_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    cnt_n = cnt_q + LEN_W'(1);
`ifdef FRAME_CKSUM_EN
                    cks_n = cks_q + bus.pl_data_i;
`endif
                    if (close_c) begin
                        state_n    = S_HDR0;
                        pl_ready_n = 1'b0;
                        busy_n     = 1'b1;
                        tx_en_n    = 1'b1;
                        tx_data_n  = HDR0;
                    end
                end
            end
            S_HDR0: begin
                if (done_c) begin
                    state_n   = S_HDR1;
                    tx_en_n   = 1'b1;
                    tx_data_n = HDR1;
                end
            end
            S_HDR1: begin
                if (done_c) begin
                    state_n   = S_LEN;
                    tx_en_n   = 1'b1;
                    tx_data_n = cnt_q;
                end
            end
            S_LEN: begin
                if (done_c) begin
                    state_n   = S_PAY;
                    idx_n     = '0;
                    tx_en_n   = 1'b1;
                    tx_data_n = rd_data_c;
                end
            end
            S_PAY: begin
                if (done_c) begin
                    if (last_pay_c) begin
`ifdef FRAME_CKSUM_EN
                        state_n   = S_CKS;
                        tx_en_n   = 1'b1;
                        tx_data_n = cks_q + cnt_q;
`else
                        state_n      = S_IDLE;
                        cnt_n        = '0;
                        idx_n        = '0;
                        pl_ready_n   = 1'b1;
                        busy_n       = 1'b0;
                        frame_done_n = 1'b1;
`endif
                    end else begin
                        idx_n     = idx_q + AW'(1);
                        tx_en_n   = 1'b1;
                        tx_data_n = rd_data_c;
                    end
                end
            end
`ifdef FRAME_CKSUM_EN
            S_CKS: begin
                if (done_c) begin
                    state_n      = S_IDLE;
                    cnt_n        = '0;
                    idx_n        = '0;
                    cks_n        = '0;
                    pl_ready_n   = 1'b1;
                    busy_n       = 1'b0;
                    frame_done_n = 1'b1;
                end
            end
`endif
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            pl_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            tx_en_q      <= 1'b0;
            tx_data_q    <= 8'h00;
`ifdef FRAME_CKSUM_EN
            cks_q        <= '0;
`endif
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            idx_q        <= idx_n;
            pl_ready_q   <= pl_ready_n;
            busy_q       <= busy_n;
            frame_done_q <= frame_done_n;
            tx_en_q      <= tx_en_n;
            tx_data_q    <= tx_data_n;
`ifdef FRAME_CKSUM_EN
            cks_q        <= cks_n;
`endif
        end
    end

    assign bus.pl_ready_o   = pl_ready_q;
    assign bus.busy_o       = busy_q;
    assign bus.frame_done_o = frame_done_q;
    assign bus.tx_en_o      = tx_en_q;
    assign bus.tx_data_o    = tx_data_q;

endmodule

// File: tb/tb_uart_frame_pack.sv
// Testbench for uart_frame_pack: directed and randomized frames checked
// against a frame-level reference model. Honours FRAME_CKSUM_EN.
module tb_uart_frame_pack;

    localparam int unsigned DEPTH = 16;
    localparam logic [7:0]  HDR0  = 8'h55;
    localparam logic [7:0]  HDR1  = 8'hAA;

    typedef logic [7:0] bq_t[$];

    logic clk;
    logic rst;
    logic model_done;
    logic spur_done;
    int unsigned tx_delay;

    int checks;
    int errors;

    // Monitor state (written only by the monitor process).
    bq_t         got;
    int unsigned cyc;
    int unsigned fd_cnt;
    int unsigned fd_bad;
    int unsigned gap_bad;
    int unsigned last_en_cyc;
    bit          en_seen;
    bit          prev_done;

    uart_frame_pack_if ifc ();

    assign ifc.tx_done_i = model_done | spur_done;

    uart_frame_pack #(
        .DEPTH (DEPTH),
        .HDR0  (HDR0),
        .HDR1  (HDR1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transmitter model: done pulse tx_delay cycles after each tx_en pulse.
    initial begin
        int unsigned cd;
        cd = 0;
        model_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            model_done = 1'b0;
            if (rst) begin
                cd = 0;
            end else if (ifc.tx_en_o) begin
                cd = tx_delay;
            end else if (cd != 0) begin
                cd = cd - 1;
                if (cd == 0) model_done = 1'b1;
            end
        end
    end

    // Monitor: captures issued bytes, pulse spacing and frame_done timing.
    initial begin
        cyc = 0; fd_cnt = 0; fd_bad = 0; gap_bad = 0;
        last_en_cyc = 0; en_seen = 1'b0; prev_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (ifc.tx_en_o === 1'b1) begin
                got.push_back(ifc.tx_data_o);
                if (en_seen && (cyc - last_en_cyc != tx_delay + 1)) gap_bad = gap_bad + 1;
                en_seen = 1'b1;
                last_en_cyc = cyc;
            end
            if (ifc.frame_done_o === 1'b1) begin
                fd_cnt = fd_cnt + 1;
                if (!prev_done) fd_bad = fd_bad + 1;
            end
            if (ifc.busy_o !== 1'b1) en_seen = 1'b0;
            prev_done = model_done;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: headers, length, payload, optional modulo-256 sum.
    function automatic bq_t model_frame(input bq_t pl);
        bq_t f;
        int unsigned s;
        f.push_back(HDR0);
        f.push_back(HDR1);
        f.push_back(8'(pl.size()));
        s = pl.size();
        foreach (pl[i]) begin
            f.push_back(pl[i]);
            s = s + int'(pl[i]);
        end
`ifdef FRAME_CKSUM_EN
        f.push_back(8'(s % 256));
`endif
        return f;
    endfunction

    task automatic compare_bytes(input string tag, input bq_t exp, input int unsigned start);
        int unsigned n;
        chk({tag, "_len"}, 32'(got.size() - start), 32'(exp.size()));
        n = (got.size() - start < exp.size()) ? got.size() - start : exp.size();
        for (int i = 0; i < int'(n); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(got[start + i]), 32'(exp[i]));
        end
    endtask

    // Waits (bounded) until frame_done_o is seen at a falling edge.
    task automatic wait_frame_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            if (ifc.frame_done_o === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_done_timeout"}, 32'(seen), 32'd1);
        chk({tag, "_ready_at_done"}, 32'(ifc.pl_ready_o), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(ifc.busy_o), 32'd0);
        @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input bq_t pl, input bit use_last, input bit spur);
        bq_t exp;
        int unsigned start;
        int unsigned fd0;
        exp   = model_frame(pl);
        start = got.size();
        fd0   = fd_cnt;
        for (int i = 0; i < pl.size(); i++) begin
            ifc.pl_valid_i = 1'b1;
            ifc.pl_data_i  = pl[i];
            ifc.pl_last_i  = use_last && (i == pl.size() - 1);
            @(negedge clk);
        end
        ifc.pl_valid_i = 1'b0;
        ifc.pl_last_i  = 1'b0;
        chk({tag, "_busy_after_close"}, 32'(ifc.busy_o), 32'd1);
        chk({tag, "_ready_after_close"}, 32'(ifc.pl_ready_o), 32'd0);
        chk({tag, "_hdr0_en"}, 32'(ifc.tx_en_o), 32'd1);
        chk({tag, "_hdr0_data"}, 32'(ifc.tx_data_o), 32'(HDR0));
        if (spur) begin
            spur_done = 1'b1;
            @(negedge clk);
            spur_done = 1'b0;
        end
        wait_frame_done(tag);
        compare_bytes(tag, exp, start);
        chk({tag, "_frame_done_count"}, 32'(fd_cnt - fd0), 32'd1);
        chk({tag, "_en_spacing_bad"}, 32'(gap_bad), 32'd0);
        chk({tag, "_done_follows_txdone_bad"}, 32'(fd_bad), 32'd0);
    endtask

    initial begin
        bq_t pl;
        bq_t exp;
        int unsigned start;
        int unsigned fd0;
        int unsigned n;
        int unsigned ens;
        int unsigned ready_viol;
        bit use_last;
        bit seen;

        checks = 0; errors = 0;
        rst = 1'b1; spur_done = 1'b0; tx_delay = 4;
        ifc.pl_data_i = 8'h00; ifc.pl_valid_i = 1'b0; ifc.pl_last_i = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ifc.pl_ready_o), 32'd1);
        chk("rst_tx_en", 32'(ifc.tx_en_o), 32'd0);
        chk("rst_tx_data", 32'(ifc.tx_data_o), 32'h00);
        chk("rst_busy", 32'(ifc.busy_o), 32'd0);
        chk("rst_frame_done", 32'(ifc.frame_done_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Spurious done in IDLE changes nothing.
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        @(negedge clk);
        chk("idle_spur_ready", 32'(ifc.pl_ready_o), 32'd1);
        chk("idle_spur_busy", 32'(ifc.busy_o), 32'd0);
        chk("idle_spur_tx_en", 32'(ifc.tx_en_o), 32'd0);

        // 01,02,03 with last, transmitter latency 10.
        tx_delay = 10;
        pl = {8'h01, 8'h02, 8'h03};
        run_frame("basic", pl, 1'b1, 1'b0);

        // DEPTH bytes of FF without last: auto-close.
        pl = {};
        for (int i = 0; i < int'(DEPTH); i++) pl.push_back(8'hFF);
        tx_delay = 3;
        run_frame("autoclose", pl, 1'b0, 1'b0);

        // Spurious done coincident with the HDR0 issue pulse.
        tx_delay = 5;
        pl = {8'h10, 8'h20};
        run_frame("spur_en", pl, 1'b1, 1'b1);

        // Randomized frames.
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, DEPTH);
            pl = {};
            for (int i = 0; i < int'(n); i++) pl.push_back(8'($urandom_range(0, 255)));
            use_last = (n < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            tx_delay = $urandom_range(1, 12);
            run_frame($sformatf("rand%0d", r), pl, use_last, 1'b0);
        end

        // pl_valid_i held high through emission: next frame only after ready.
        tx_delay = 2;
        pl = {8'hA1, 8'hB2, 8'hC3};
        exp = model_frame(pl);
        begin
            bq_t pl2;
            bq_t exp2;
            pl2 = {8'h3C};
            exp2 = model_frame(pl2);
            foreach (exp2[i]) exp.push_back(exp2[i]);
        end
        start = got.size();
        fd0 = fd_cnt;
        for (int i = 0; i < pl.size(); i++) begin
            ifc.pl_valid_i = 1'b1;
            ifc.pl_data_i  = pl[i];
            ifc.pl_last_i  = (i == pl.size() - 1);
            @(negedge clk);
        end
        ifc.pl_data_i = 8'h3C;
        ifc.pl_last_i = 1'b1;
        ready_viol = 0;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            if (ifc.frame_done_o === 1'b1) seen = 1'b1;
            else begin
                if (ifc.busy_o === 1'b1 && ifc.pl_ready_o !== 1'b0) ready_viol = ready_viol + 1;
                @(negedge clk);
            end
        end
        chk("hold_first_done_timeout", 32'(seen), 32'd1);
        @(negedge clk);
        ifc.pl_valid_i = 1'b0;
        ifc.pl_last_i  = 1'b0;
        chk("hold_second_busy", 32'(ifc.busy_o), 32'd1);
        wait_frame_done("hold_second");
        chk("hold_ready_while_busy", 32'(ready_viol), 32'd0);
        compare_bytes("hold", exp, start);
        chk("hold_frame_done_count", 32'(fd_cnt - fd0), 32'd2);

        // Reset during the S_PAY wait, then a 1-byte frame.
        tx_delay = 10;
        pl = {8'h11, 8'h22, 8'h33};
        fd0 = fd_cnt;
        for (int i = 0; i < pl.size(); i++) begin
            ifc.pl_valid_i = 1'b1;
            ifc.pl_data_i  = pl[i];
            ifc.pl_last_i  = (i == pl.size() - 1);
            @(negedge clk);
        end
        ifc.pl_valid_i = 1'b0;
        ifc.pl_last_i  = 1'b0;
        ens = 0;
        for (int k = 0; k < 500 && ens < 4; k++) begin
            if (ifc.tx_en_o === 1'b1) ens = ens + 1;
            @(negedge clk);
        end
        chk("midrst_reach_pay", 32'(ens), 32'd4);
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(ifc.pl_ready_o), 32'd1);
        chk("midrst_tx_en", 32'(ifc.tx_en_o), 32'd0);
        chk("midrst_tx_data", 32'(ifc.tx_data_o), 32'h00);
        chk("midrst_busy", 32'(ifc.busy_o), 32'd0);
        chk("midrst_frame_done", 32'(ifc.frame_done_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
        pl = {8'h7E};
        run_frame("after_rst", pl, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_pack.md
# uart_frame_pack

Transmit-side framer for the UART command link: collects a payload from an upstream producer into a local buffer and emits one complete frame byte-by-byte into `uart_tx_5`. It is the outbound counterpart of the receive-side order/verify stage. That stage strips and checks frames; this block builds them. It sits between application logic and the transmitter, pacing each byte on the transmitter's done pulse.

## Interface
Parameters:
- `DEPTH`, 16: maximum payload bytes per frame (2..255).
- `HDR0`, 8'h55: first header byte.
- `HDR1`, 8'hAA: second header byte.

Ports:
- `clk_i` input 1: single clock, all logic rising-edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `pl_data_i` input 8: payload byte.
- `pl_valid_i` input 1: payload byte valid.
- `pl_last_i` input 1: qualifies `pl_data_i` as the final payload byte.
- `pl_ready_o` output 1: block accepts a payload byte this cycle.
- `tx_data_o` output 8: byte to transmitter.
- `tx_en_o` output 1: one-cycle start pulse to transmitter.
- `tx_done_i` input 1: one-cycle pulse, transmitter finished the current byte.
- `busy_o` output 1: frame emission in progress.
- `frame_done_o` output 1: one-cycle pulse, last frame byte completed.

## Operation
- Frame order: `HDR0`, `HDR1`, LEN, payload[0..LEN-1], optional CKS.
  - LEN is the accepted byte count, 1..DEPTH.
- Collect phase (state IDLE):
  - `pl_ready_o`=1.
  - A byte is accepted when `pl_valid_i & pl_ready_o`; it is written to buffer[cnt] and cnt increments.
  - Accepting a byte with `pl_last_i`=1, or accepting the DEPTH-th byte, closes the frame. The DEPTH-th byte is closed as if `pl_last_i` were set.
  - Close moves the FSM to S_HDR0, and `pl_ready_o` drops the next cycle.
- States: IDLE -> S_HDR0 -> S_HDR1 -> S_LEN -> S_PAY (repeats LEN times) -> S_CKS (if enabled) -> IDLE.
- Each send state has two phases:
  - Issue: `tx_en_o`=1 for one cycle, `tx_data_o` loaded.
  - Wait: hold `tx_data_o`, wait for `tx_done_i`.
  - On `tx_done_i`, advance to the next state, or to the next payload index within S_PAY.
- Checksum: 8-bit sum modulo 256 of LEN and all payload bytes. HDR bytes are excluded.
- On return to IDLE: cnt and index are cleared and `frame_done_o` pulses.
- `pl_ready_o`=0 whenever `busy_o`=1. `pl_valid_i` is ignored outside IDLE.

## Timing
- Reset values:
  - `pl_ready_o`=1.
  - `tx_en_o`=0, `tx_data_o`=8'h00, `busy_o`=0, `frame_done_o`=0.
  - FSM=IDLE, cnt=0.
- Close-accept in cycle N:
  - `busy_o`=1 and `pl_ready_o`=0 from N+1.
  - First `tx_en_o` (HDR0) in N+1.
- `tx_done_i` in cycle M: next `tx_en_o` in M+1.
- `tx_done_i` in the same cycle as `tx_en_o`, or in IDLE, is ignored.
- After the final byte's `tx_done_i` in cycle M:
  - `frame_done_o`=1 in M+1, `busy_o`=0 in M+1.
  - `pl_ready_o`=1 in M+1.
- Reset mid-frame: all outputs revert to reset values immediately. The buffer is discarded and no `frame_done_o` pulse is generated.
- Output registers: `tx_data_o` and `tx_en_o` are driven from flops.

## Configuration
- `FRAME_CKSUM_EN` defined: S_CKS is present and the checksum byte is appended. Frame length = LEN+4.
- `FRAME_CKSUM_EN` undefined: there is no S_CKS state and no checksum adder. `frame_done_o` follows the last payload byte. Frame length = LEN+3.

## Structure
- Package `uart_frame_pkg`:
  - State enum.
  - Default `HDR0`/`HDR1` constants.
  - Checksum width constant (8).
- One sub-module, `uart_frame_buf`: DEPTH×8 register buffer with write port (data, we, wr index) and a combinational read port addressed by the FSM's payload index.

## Test plan
- Payload 0x01,0x02,0x03 (last on 0x03) with cksum enabled, transmitter model returning `tx_done_i` 10 cycles after each `tx_en_o` -> bytes 55,AA,03,01,02,03,09. Exactly 7 `tx_en_o` pulses, then one `frame_done_o`.
- Same payload with `FRAME_CKSUM_EN` undefined -> 55,AA,03,01,02,03. `frame_done_o` in the cycle after the 6th `tx_done_i`.
- 16 bytes 0xFF with no `pl_last_i` (DEPTH=16) -> frame auto-closes after byte 16. LEN=0x10, CKS=(0x10+16×0xFF) mod 256 = 0x00.
- `pl_valid_i` held high during emission -> no byte accepted while `busy_o`=1. The next frame starts collecting only after `pl_ready_o` returns.
- Assert `rst_i` during the S_PAY wait -> outputs at reset values next edge, no `frame_done_o`. A following 1-byte payload 0x7E yields 55,AA,01,7E,7F.
- Spurious `tx_done_i` in IDLE and coincident with `tx_en_o` -> no state advance, byte sequence unchanged.
